// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: next-PC controls from the control/ALU path and the
// resulting PC/adder outputs towards instruction memory.
interface pc_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  en;
  logic [1:0]            pc_src;
  logic [31:0]           imm;
  logic [31:0]           jr_target;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] pc_target;
  logic                  misaligned;

  // Control side: drives the select/operands, observes the PC.
  modport master (
    output en, pc_src, imm, jr_target,
    input  pc, pc_plus4, pc_target, misaligned
  );

  // Fetch unit side.
  modport slave (
    input  en, pc_src, imm, jr_target,
    output pc, pc_plus4, pc_target, misaligned
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter register with sequential / branch / jump-register next-PC
// selection. The only state is the PC; every other output is combinational.
module pc_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INCREMENT    = 4
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_unit_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INCREMENT);

  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] plus4;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] raw_next;

  // Both adders are modulo 2^ADDR_WIDTH; a negative imm works through
  // truncation of its two's-complement value.
  assign plus4  = pc_reg + STEP;
  assign target = pc_reg + bus.imm[ADDR_WIDTH-1:0];

  // Candidate next PC before alignment. The JALR rule (clear bit 0) is
  // subsumed by the two-bit alignment mask below, so jr_target is taken raw
  // here and its low bits still feed the misaligned flag.
  always_comb begin
    raw_next = plus4;
    case (bus.pc_src)
      2'b01:   raw_next = target;
      2'b10:   raw_next = bus.jr_target[ADDR_WIDTH-1:0];
      default: raw_next = plus4;  // 00 sequential, 11 reserved -> sequential
    endcase
  end

  // Force word alignment: bits [1:0] cleared, upper bits pass through.
  generate
    for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_align
      if (gi < 2) begin : g_low
        assign pc_next[gi] = 1'b0;
      end else begin : g_pass
        assign pc_next[gi] = raw_next[gi];
      end
    end
  endgenerate

  // Operand bits above the address width play no part in fetch addressing.
  generate
    if (ADDR_WIDTH < 32) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^{bus.imm[31:ADDR_WIDTH], bus.jr_target[31:ADDR_WIDTH]};
    end
  endgenerate

  // PC register: reset wins immediately; en=0 stalls regardless of pc_src.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_VECTOR;
    end else if (bus.en) begin
      pc_reg <= pc_next;
    end
  end

  assign bus.pc         = pc_reg;
  assign bus.pc_plus4   = plus4;
  assign bus.pc_target  = target;
  assign bus.misaligned = |raw_next[1:0];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the driver pushes expected outputs per
// cycle from an arithmetic model, the monitor pops and compares at negedge.
module tb_pc_fetch_unit;
  localparam int AW = 16;
  localparam int unsigned MOD = 65536;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

  pc_fetch_unit #(
    .ADDR_WIDTH  (AW),
    .RESET_VECTOR(16'h0000),
    .INCREMENT   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int unsigned pc;
    int unsigned plus4;
    int unsigned target;
    bit          mis;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state: the architectural PC and last cycle's controls.
  int unsigned m_pc      = 0;
  bit          prev_rst  = 1'b1;
  bit          prev_en   = 1'b0;
  int unsigned prev_next = 0;

  function automatic int unsigned model_raw(input int unsigned cur, input logic [1:0] src,
                                            input int unsigned im, input int unsigned jr);
    int unsigned s;
    case (src)
      2'd1:    s = cur + im;   // wraps mod 2^32, then mod 2^16 below
      2'd2:    s = jr;
      default: s = cur + 4;
    endcase
    return s % MOD;
  endfunction

  task automatic step(input bit r, input bit e, input logic [1:0] s,
                      input int unsigned im, input int unsigned jr, input string tag);
    exp_t x;
    int unsigned raw;
    @(posedge clk);
    if (prev_rst) m_pc = 0;
    else if (prev_en) m_pc = prev_next;
    #1;
    bus.en        = e;
    bus.pc_src    = s;
    bus.imm       = im;
    bus.jr_target = jr;
    #2;
    rst = r;  // mid-cycle, away from both clock edges
    if (r) m_pc = 0;
    raw      = model_raw(m_pc, s, im, jr);
    x.pc     = m_pc;
    x.plus4  = (m_pc + 4) % MOD;
    x.target = (m_pc + im) % MOD;
    x.mis    = (raw % 4) != 0;
    x.tag    = tag;
    sb_q.push_back(x);
    prev_rst  = r;
    prev_en   = e;
    prev_next = raw - (raw % 4);
  endtask

  // Monitor: one scoreboard entry per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      n_vec++;
      if (32'(bus.pc) !== x.pc) begin
        n_err++;
        $display("FAIL %s pc: got %h want %h", x.tag, bus.pc, x.pc[15:0]);
      end
      if (32'(bus.pc_plus4) !== x.plus4) begin
        n_err++;
        $display("FAIL %s pc_plus4: got %h want %h", x.tag, bus.pc_plus4, x.plus4[15:0]);
      end
      if (32'(bus.pc_target) !== x.target) begin
        n_err++;
        $display("FAIL %s pc_target: got %h want %h", x.tag, bus.pc_target, x.target[15:0]);
      end
      if (bus.misaligned !== x.mis) begin
        n_err++;
        $display("FAIL %s misaligned: got %b want %b", x.tag, bus.misaligned, x.mis);
      end
      $display("vec %0d %s pc=%h plus4=%h target=%h mis=%b", n_vec, x.tag,
               bus.pc, bus.pc_plus4, bus.pc_target, bus.misaligned);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0; bus.pc_src = 2'b00; bus.imm = '0; bus.jr_target = '0;
    // Reset, then sequential fetch 0 -> 4 -> 8 -> C -> 10.
    step(1, 0, 2'd0, 0, 0, "reset");
    step(1, 1, 2'd1, 32'h40, 0, "reset_dom");
    step(0, 1, 2'd0, 0, 0, "seq0");
    for (int i = 0; i < 3; i++) step(0, 1, 2'd0, 0, 0, "seq");
    // Stall at 0x10 with a pending branch, then take it -> 0x50.
    for (int i = 0; i < 3; i++) step(0, 0, 2'd1, 32'h40, 0, "stall");
    step(0, 1, 2'd1, 32'h40, 0, "br_fwd");
    // Backward branch from 0x20 by -16.
    step(0, 1, 2'd2, 0, 32'h20, "jr20");
    step(0, 1, 2'd1, 32'hFFFF_FFF0, 0, "br_back");
    // JALR to an odd target, landing on 0x1234.
    step(0, 1, 2'd2, 0, 32'h0000_1235, "jalr");
    step(0, 1, 2'd2, 0, 32'h0, "to0");
    // Misaligned branch from 0 by +6 -> 0x4.
    step(0, 1, 2'd1, 32'h6, 0, "br_mis");
    step(0, 1, 2'd3, 0, 0, "rsvd");
    // Wrap from 0xFFFC.
    step(0, 1, 2'd2, 0, 32'h0000_FFFC, "jr_top");
    step(0, 1, 2'd0, 0, 0, "wrap");
    step(0, 1, 2'd1, 32'h0001_0008, 0, "br_wrap");
    // Asynchronous reset mid-run at 0x100, held over two edges.
    step(0, 1, 2'd2, 0, 32'h100, "jr100");
    step(0, 0, 2'd0, 0, 0, "at100");
    step(1, 1, 2'd0, 0, 0, "async_rst");
    step(1, 1, 2'd1, 32'h40, 0, "rst_hold");
    step(1, 1, 2'd2, 0, 32'h80, "rst_hold");
    step(0, 1, 2'd0, 0, 0, "rst_rel");
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit          r, e;
      logic [1:0]  s;
      int unsigned im;
      r  = ($urandom_range(0, 99) < 3);
      e  = ($urandom_range(0, 99) < 80);
      s  = 2'($urandom_range(0, 3));
      im = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($signed(10'($urandom())));
      step(r, e, s, im, $urandom(), "rand");
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch address generator for the single-cycle RISC-V core.
- Holds the program counter (PC) register and computes the sequential address PC+4 and the branch target PC+imm.
- Selects the next PC each cycle and drives the instruction-memory address bus.
- Sits between the control/ALU path and instruction memory.

Parameters:
- ADDR_WIDTH, 16, width of the PC and the instruction-memory address.
- RESET_VECTOR, 0, PC value loaded on reset.
- INCREMENT, 4, sequential step in bytes.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  PC update enable; low = stall, PC holds.
- pc_src  input  2  next-PC select: 00 sequential, 01 branch (PC+imm), 10 jump-register target, 11 reserved.
- imm  input  32  sign-extended branch/jump offset (two's complement).
- jr_target  input  32  absolute target from the ALU (JALR).
- pc  output  ADDR_WIDTH  current PC, registered.
- pc_plus4  output  ADDR_WIDTH  PC+INCREMENT, combinational.
- pc_target  output  ADDR_WIDTH  PC+imm, combinational.
- misaligned  output  1  selected next-PC had nonzero bits [1:0] before masking, combinational.

Behaviour:
- Reset: while rst=1, pc=RESET_VECTOR immediately, asynchronous to clk. Reset dominates en and pc_src. First update occurs on the first rising clk edge after rst falls.
- Adders:
  - Purely combinational, width ADDR_WIDTH.
  - pc_plus4 = (pc + INCREMENT) mod 2^ADDR_WIDTH.
  - pc_target = (pc + imm[ADDR_WIDTH-1:0]) mod 2^ADDR_WIDTH.
  - Carry-out is discarded.
  - Negative imm works by truncation of the two's-complement value.
- Next-PC selection:
  - 00: pc_plus4.
  - 01: pc_target.
  - 10: jr_target[ADDR_WIDTH-1:0] with bit 0 cleared (JALR rule).
  - 11: treated as 00.
- Alignment:
  - The selected value has bits [1:0] forced to 00 before being registered.
  - misaligned=1 when the pre-mask bits [1:0] are nonzero; otherwise 0.
  - misaligned is informational only and never blocks the update.
- Register update: on each rising clk edge with rst=0 and en=1, pc <= masked next-PC. With en=0, pc holds and pc_src/imm/jr_target are ignored.
- Latency:
  - pc changes one cycle after selection.
  - pc_plus4 and pc_target follow pc combinationally within the same cycle.
  - No internal state other than pc.
- Wrap-around: pc at 2^ADDR_WIDTH-4 with sequential select wraps to 0. Branch targets outside the range wrap the same way.
- Reset mid-operation: asserting rst at any time, including mid-cycle or during a stall, forces pc to RESET_VECTOR without waiting for a clock edge.
- Simultaneous events: rst beats en; en=0 beats any pc_src value.
- No X propagation: with rst asserted, all outputs are defined.

Test Plan:
- Reset/sequential: assert rst -> pc=0x0000. Release rst, en=1, pc_src=00 for 4 edges -> pc 0x0004, 0x0008, 0x000C, 0x0010; pc_plus4 always pc+4.
- Stall: at pc=0x0010, en=0 for 3 edges with pc_src=01 and imm=0x40 -> pc stays 0x0010. Then en=1 -> 0x0050.
- Backward branch: pc=0x0020, pc_src=01, imm=0xFFFFFFF0 (-16) -> pc_target=0x0010; next pc=0x0010; misaligned=0.
- JALR: jr_target=0x00001235, pc_src=10 -> next pc=0x1234, misaligned=1. Separately, imm=0x6 with pc_src=01 from pc=0x0000 -> pc=0x0004, misaligned=1.
- Wrap: pc=0xFFFC, pc_src=00 -> pc_plus4=0x0000; next pc=0x0000.
- Async reset mid-run: at pc=0x0100, raise rst between clock edges -> pc=0x0000 before the next edge. Hold rst over 2 edges -> pc stays 0x0000.
